maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_pkg.sv | 35 +++
 rtl/maxpool_stream_if.sv | 28 ++
 rtl/pool_partial_buf.sv | 62 ++++++
 rtl/maxpool_stream.sv | 141 ++++++++++++++
 tb/tb_maxpool_stream.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_pkg : shared sizing helpers and window seed values for maxpool.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package maxpool_pkg;

  localparam int DATA_W_DEF = 16;

  // Seeds stored left-justified in 64 bits; seed_of() shifts to the pixel width.
  localparam logic signed [63:0] SEED_ZERO = 64'sd0;
  localparam logic signed [63:0] SEED_MSB  = 64'sh8000_0000_0000_0000;

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  function automatic int rows_held(input int k, input int s);
    return (k + s - 1) / s;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] seed_of(input int w, input int floor_zero);
    return (floor_zero != 0) ? SEED_ZERO : (SEED_MSB >> (64 - w));
  endfunction

  function automatic logic in_win(input int pos, input int start, input int len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_stream_if : pixel-in / result-out handshake bundle for maxpool.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface maxpool_stream_if import maxpool_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/pool_partial_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pool_partial_buf : OUT_W x NR running window maxima, one slot per live row. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pool_partial_buf import maxpool_pkg::*; #(
  parameter int              DATA_W = DATA_W_DEF,
  parameter int              OUT_W  = 1,
  parameter int              NR     = 1,
  parameter logic [DATA_W-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] pix_i,
  input  logic [OUT_W-1:0]  col_hit_i,
  input  logic [OUT_W-1:0]  col_end_i,
  input  logic [NR-1:0]     row_hit_i,
  input  logic [NR-1:0]     row_end_i,
  output logic [DATA_W-1:0] result_o,
  output logic              done_o
);
  localparam int N = OUT_W * NR;

  logic [DATA_W-1:0] w_res_acc [N+1];
  logic              w_done_acc [N+1];

  assign w_res_acc[0]  = '0;
  assign w_done_acc[0] = 1'b0;

  for (genvar ox = 0; ox < OUT_W; ox++) begin : g_col
    for (genvar s = 0; s < NR; s++) begin : g_slot
      localparam int IDX = ox * NR + s;
      logic [DATA_W-1:0] ent_q, ent_d, w_cand;
      logic              w_hit, w_fin;

      assign w_hit  = col_hit_i[ox] && row_hit_i[s];
      assign w_fin  = w_hit && col_end_i[ox] && row_end_i[s];
      assign w_cand = ($signed(pix_i) > $signed(ent_q)) ? pix_i : ent_q;

      // A finished window hands its value out and reseeds for the row that reuses this slot.
      always_comb begin
        ent_d = ent_q;
        if (clear_i || (upd_i && w_fin)) ent_d = SEED;
        else if (upd_i && w_hit)         ent_d = w_cand;
      end

      always_ff @(posedge clk) begin
        if (rst) ent_q <= SEED;
        else     ent_q <= ent_d;
      end

      assign w_res_acc[IDX+1]  = w_res_acc[IDX] | (w_fin ? w_cand : '0);
      assign w_done_acc[IDX+1] = w_done_acc[IDX] | w_fin;
    end
  end

  assign result_o = w_res_acc[N];
  assign done_o   = w_done_acc[N];
endmodule
`default_nettype wire

// File: rtl/maxpool_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_stream : streaming KxK / STRIDE signed max-pool over raster pixels. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module maxpool_stream import maxpool_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IMG_W      = 111,
  parameter int IMG_H      = 111,
  parameter int K          = 3,
  parameter int STRIDE     = 2,
  parameter int CHANNELS   = 64,
  parameter int FLOOR_ZERO = 1
) (
  input logic              clk,
  input logic              rst,
  maxpool_stream_if.slave  bus
);
  localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
  localparam int NR       = rows_held(K, STRIDE);
  localparam int COL_W    = cnt_w(IMG_W);
  localparam int ROW_W    = cnt_w(IMG_H);
  localparam int CH_W     = cnt_w(CHANNELS);
  localparam int LAST_COL = (OUT_W - 1) * STRIDE + K - 1;
  localparam int LAST_ROW = (OUT_H - 1) * STRIDE + K - 1;
  localparam logic [DATA_W-1:0] SEED = DATA_W'(seed_of(DATA_W, FLOOR_ZERO));

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              out_valid_q, out_last_q, out_final_q, frame_done_q;
  logic [DATA_W-1:0] out_data_q;

  logic              w_in_ready, w_accept, w_col_wrap, w_row_wrap, w_ch_wrap, w_win_last;
  logic [OUT_W-1:0]  w_col_hit, w_col_end;
  logic [OUT_H-1:0]  w_row_in, w_row_bot;
  logic [NR-1:0]     w_row_hit, w_row_end;
  logic [DATA_W-1:0] w_result;
  logic              w_done;

  assign w_in_ready = !out_valid_q || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_col_wrap = (int'(col_q) == IMG_W - 1);
  assign w_row_wrap = (int'(row_q) == IMG_H - 1);
  assign w_ch_wrap  = (int'(ch_q) == CHANNELS - 1);
  assign w_win_last = (int'(row_q) == LAST_ROW) && (int'(col_q) == LAST_COL);

  for (genvar ox = 0; ox < OUT_W; ox++) begin : g_col_dec
    assign w_col_hit[ox] = in_win(int'(col_q), ox * STRIDE, K);
    assign w_col_end[ox] = (int'(col_q) == ox * STRIDE + K - 1);
  end

  for (genvar oy = 0; oy < OUT_H; oy++) begin : g_row_dec
    assign w_row_in[oy]  = in_win(int'(row_q), oy * STRIDE, K);
    assign w_row_bot[oy] = (int'(row_q) == oy * STRIDE + K - 1);
  end

  // Output row oy lives in slot oy % NR; overlapping live rows never share a slot.
  for (genvar s = 0; s < NR; s++) begin : g_slot
    logic [OUT_H-1:0] w_sel_in, w_sel_bot;
    for (genvar oy = 0; oy < OUT_H; oy++) begin : g_oy
      assign w_sel_in[oy]  = (oy % NR == s) ? w_row_in[oy]  : 1'b0;
      assign w_sel_bot[oy] = (oy % NR == s) ? w_row_bot[oy] : 1'b0;
    end
    assign w_row_hit[s] = |w_sel_in;
    assign w_row_end[s] = |w_sel_bot;
  end

  pool_partial_buf #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .NR     (NR),
    .SEED   (SEED)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_accept && w_col_wrap && w_row_wrap),
    .upd_i     (w_accept),
    .pix_i     (bus.in_data),
    .col_hit_i (w_col_hit),
    .col_end_i (w_col_end),
    .row_hit_i (w_row_hit),
    .row_end_i (w_row_end),
    .result_o  (w_result),
    .done_o    (w_done)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (w_accept) begin
      if (w_col_wrap) begin
        col_d = '0;
        if (w_row_wrap) begin
          row_d = '0;
          ch_d  = w_ch_wrap ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_final_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ch_q         <= ch_d;
      frame_done_q <= out_valid_q && bus.out_ready && out_last_q && out_final_q;
      if (w_accept && w_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_result;
        out_last_q  <= w_win_last;
        out_final_q <= w_ch_wrap;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_maxpool_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maxpool_stream : randomized self-checking bench for maxpool_stream.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_maxpool_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          sel;
  logic        drv_valid, drv_ready;
  logic [15:0] drv_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_frame_done;
  logic [15:0] w_out_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cw, chh, ck, cs, cc, cfz;

  logic [15:0] px_q[$];
  logic [15:0] exp_d[$];
  logic        exp_l[$];
  logic [15:0] got_d[$];
  logic        got_l[$];
  int          hs_cyc[$], last_cyc[$], fd_cyc[$], acc_cyc[$];

  maxpool_stream_if #(.DATA_W(16)) ifa ();
  maxpool_stream_if #(.DATA_W(16)) ifb ();
  maxpool_stream_if #(.DATA_W(16)) ifc ();
  maxpool_stream_if #(.DATA_W(16)) ifd ();
  maxpool_stream_if #(.DATA_W(16)) ife ();

  maxpool_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .CHANNELS(2), .FLOOR_ZERO(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  maxpool_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .CHANNELS(1), .FLOOR_ZERO(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  maxpool_stream #(.DATA_W(16), .IMG_W(111), .IMG_H(111), .K(3), .STRIDE(2), .CHANNELS(1), .FLOOR_ZERO(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  maxpool_stream #(.DATA_W(16), .IMG_W(7), .IMG_H(6), .K(4), .STRIDE(1), .CHANNELS(2), .FLOOR_ZERO(0))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));
  maxpool_stream #(.DATA_W(16), .IMG_W(7), .IMG_H(5), .K(2), .STRIDE(2), .CHANNELS(3), .FLOOR_ZERO(1))
    dut_e (.clk(clk), .rst(rst), .bus(ife));

  assign ifa.in_valid = drv_valid && (sel == 0); assign ifa.in_data = drv_data; assign ifa.out_ready = drv_ready;
  assign ifb.in_valid = drv_valid && (sel == 1); assign ifb.in_data = drv_data; assign ifb.out_ready = drv_ready;
  assign ifc.in_valid = drv_valid && (sel == 2); assign ifc.in_data = drv_data; assign ifc.out_ready = drv_ready;
  assign ifd.in_valid = drv_valid && (sel == 3); assign ifd.in_data = drv_data; assign ifd.out_ready = drv_ready;
  assign ife.in_valid = drv_valid && (sel == 4); assign ife.in_data = drv_data; assign ife.out_ready = drv_ready;

  always_comb begin
    {w_in_ready, w_out_valid, w_out_data, w_out_last, w_frame_done} =
      {ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_last, ifa.frame_done};
    case (sel)
      1: {w_in_ready, w_out_valid, w_out_data, w_out_last, w_frame_done} =
           {ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_last, ifb.frame_done};
      2: {w_in_ready, w_out_valid, w_out_data, w_out_last, w_frame_done} =
           {ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.out_last, ifc.frame_done};
      3: {w_in_ready, w_out_valid, w_out_data, w_out_last, w_frame_done} =
           {ifd.in_ready, ifd.out_valid, ifd.out_data, ifd.out_last, ifd.frame_done};
      4: {w_in_ready, w_out_valid, w_out_data, w_out_last, w_frame_done} =
           {ife.in_ready, ife.out_valid, ife.out_data, ife.out_last, ife.frame_done};
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (drv_valid && w_in_ready) acc_cyc.push_back(cyc);
    if (w_out_valid && drv_ready) begin
      got_d.push_back(w_out_data);
      got_l.push_back(w_out_last);
      hs_cyc.push_back(cyc);
      if (w_out_last) last_cyc.push_back(cyc);
    end
    if (w_frame_done) fd_cyc.push_back(cyc);
  end

  task automatic set_cfg(input int s);
    sel = s;
    case (s)
      0: begin cw = 5;   chh = 5;   ck = 3; cs = 2; cc = 2; cfz = 1; end
      1: begin cw = 5;   chh = 5;   ck = 3; cs = 2; cc = 1; cfz = 0; end
      2: begin cw = 111; chh = 111; ck = 3; cs = 2; cc = 1; cfz = 1; end
      3: begin cw = 7;   chh = 6;   ck = 4; cs = 1; cc = 2; cfz = 0; end
      default: begin cw = 7; chh = 5; ck = 2; cs = 2; cc = 3; cfz = 1; end
    endcase
    px_q.delete(); exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
    hs_cyc.delete(); last_cyc.delete(); fd_cyc.delete(); acc_cyc.delete();
  endtask

  function automatic logic [15:0] rnd_px();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Brute-force window scan over every channel held in px_q.
  task automatic build_expected();
    int ow = (cw - ck) / cs + 1;
    int oh = (chh - ck) / cs + 1;
    int nch = px_q.size() / (cw * chh);
    for (int g = 0; g < nch; g++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          int m = (cfz != 0) ? 0 : -32768;
          for (int ky = 0; ky < ck; ky++)
            for (int kx = 0; kx < ck; kx++) begin
              int v = int'($signed(px_q[g*cw*chh + (oy*cs+ky)*cw + ox*cs + kx]));
              if (v > m) m = v;
            end
          exp_d.push_back(16'(m));
          exp_l.push_back((oy == oh - 1) && (ox == ow - 1));
        end
  endtask

  task automatic drive_stream(input int stall_pct, input int bubble_pct, input bit force_stall);
    int idx = 0, n = 0, stall_left = 0;
    bit stall_used = 0;
    logic [15:0] held = '0;
    build_expected();
    while ((idx < px_q.size() || got_d.size() < exp_d.size()) && n < 20000) begin
      @(posedge clk); #1; n++;
      if (force_stall && !stall_used && got_d.size() >= 1 && w_out_valid) begin
        stall_left = 10; stall_used = 1; held = w_out_data;
      end
      drv_valid = (idx < px_q.size()) && ($urandom_range(99) >= bubble_pct);
      drv_data  = (idx < px_q.size()) ? px_q[idx] : 16'h0000;
      drv_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (stall_left > 0) begin
        checks++;
        if (w_in_ready !== 1'b0 || w_out_valid !== 1'b1 || w_out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: in_ready=%b out_valid=%b out_data=%h, required 0 1 %h",
                   w_in_ready, w_out_valid, w_out_data, held);
        end
        stall_left--;
      end
      if (drv_valid && w_in_ready) idx++;
    end
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL drive_timeout: got %0d results after %0d cycles, required %0d", got_d.size(), n, exp_d.size());
    end
  endtask

  task automatic test_reset();
    set_cfg(0);
    @(negedge clk);
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", w_out_valid); end
    checks++; if (w_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", w_out_last); end
    checks++; if (w_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", w_frame_done); end
    checks++; if (w_out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h required 0000", w_out_data); end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", w_in_ready); end
  endtask

  task automatic test_ramp();
    logic [15:0] ref4 [4] = '{16'd12, 16'd14, 16'd22, 16'd24};
    set_cfg(0);
    for (int i = 0; i < 25; i++) px_q.push_back(16'((i / 5) * 5 + (i % 5)));
    for (int i = 0; i < 25; i++) px_q.push_back(16'h0100);
    drive_stream(0, 0, 0);
    checks++;
    if (got_d.size() != 8) begin errors++; $display("FAIL ramp_count: got %0d required 8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      logic [15:0] want = (i < 4) ? ref4[i] : 16'h0100;
      int pix = (i / 4) * 25 + (((i % 4) / 2) * 2 + 2) * 5 + (i % 2) * 2 + 2;
      checks++;
      if (got_d[i] !== want || got_d[i] !== exp_d[i] || got_l[i] !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL ramp_result[%0d]: got %h last=%b required %h last=%b", i, got_d[i], got_l[i], want, (i == 3 || i == 7));
      end
      checks++;
      if (hs_cyc[i] != acc_cyc[pix] + 1) begin
        errors++; $display("FAIL ramp_latency[%0d]: out at cycle %0d required %0d", i, hs_cyc[i], acc_cyc[pix] + 1);
      end
    end
    checks++;
    if (fd_cyc.size() != 1 || last_cyc.size() != 2 || fd_cyc[0] != last_cyc[1] + 1) begin
      errors++; $display("FAIL ramp_frame_done: pulses=%0d lasts=%0d required 1 pulse one cycle after last", fd_cyc.size(), last_cyc.size());
    end
  endtask

  task automatic test_floor();
    for (int s = 0; s < 2; s++) begin
      logic [15:0] want = (s == 0) ? 16'h0000 : 16'hFF00;
      set_cfg(s);
      for (int i = 0; i < cw * chh * cc; i++) px_q.push_back(16'hFF00);
      drive_stream(20, 20, 0);
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL floor_count[%0d]: got %0d required %0d", s, got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== want || exp_d[i] !== want) begin errors++; $display("FAIL floor_value[%0d][%0d]: got %h required %h", s, i, got_d[i], want); end
      end
    end
  endtask

  task automatic test_random(input int s, input int frames, input int stall_pct, input int bubble_pct, input bit force_stall);
    set_cfg(s);
    for (int i = 0; i < frames * cw * chh * cc; i++) px_q.push_back(rnd_px());
    drive_stream(stall_pct, bubble_pct, force_stall);
    checks++;
    if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d required %0d", s, got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL rand_result[%0d][%0d]: got %h last=%b required %h last=%b", s, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (fd_cyc.size() != frames) begin errors++; $display("FAIL rand_frame_done[%0d]: got %0d pulses required %0d", s, fd_cyc.size(), frames); end
    for (int f = 0; f < fd_cyc.size() && f < frames && (f * cc + cc - 1) < last_cyc.size(); f++) begin
      checks++;
      if (fd_cyc[f] != last_cyc[f * cc + cc - 1] + 1) begin
        errors++; $display("FAIL rand_frame_done_time[%0d]: cycle %0d required %0d", s, fd_cyc[f], last_cyc[f * cc + cc - 1] + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    int k = 0, n = 0;
    set_cfg(0);
    while (k < 7 && n < 100) begin
      @(posedge clk); #1; n++;
      drv_valid = 1'b1; drv_data = rnd_px(); drv_ready = 1'b1;
      @(negedge clk);
      if (w_in_ready) k++;
    end
    @(posedge clk); #1;
    drv_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (k != 7 || w_out_valid !== 1'b0 || w_out_data !== 16'h0000) begin
      errors++; $display("FAIL mid_reset_clear: accepted=%0d out_valid=%b out_data=%h required 7 0 0000", k, w_out_valid, w_out_data);
    end
    set_cfg(0);
    for (int i = 0; i < 50; i++) px_q.push_back(16'(((i % 25) / 5) * 5 + (i % 5)));
    drive_stream(0, 0, 0);
    checks++;
    if (got_d.size() != 8) begin errors++; $display("FAIL mid_reset_count: got %0d required 8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      logic [15:0] want = 16'(10 * ((i % 4) / 2) + 2 * (i % 2) + 12);
      checks++;
      if (got_d[i] !== want || got_l[i] !== ((i % 4) == 3)) begin
        errors++; $display("FAIL mid_reset_result[%0d]: got %h last=%b required %h last=%b", i, got_d[i], got_l[i], want, ((i % 4) == 3));
      end
    end
  endtask

  task automatic test_big();
    int nonzero = 0;
    set_cfg(2);
    for (int i = 0; i < 111 * 111; i++) px_q.push_back((i == 110 * 111 + 110) ? 16'h7FFF : 16'h0000);
    drive_stream(0, 0, 0);
    checks++;
    if (got_d.size() != 3025) begin errors++; $display("FAIL big_count: got %0d required 3025", got_d.size()); end
    else begin
      for (int i = 0; i < 3024; i++) if (got_d[i] !== 16'h0000 || got_d[i] !== exp_d[i]) nonzero++;
      checks++;
      if (nonzero != 0) begin errors++; $display("FAIL big_zero_results: %0d wrong, required 0", nonzero); end
      checks++;
      if (got_d[3024] !== 16'h7FFF || got_l[3024] !== 1'b1) begin
        errors++; $display("FAIL big_last_result: got %h last=%b required 7fff last=1", got_d[3024], got_l[3024]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; drv_valid = 1'b0; drv_ready = 1'b1; drv_data = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_ramp();
    test_floor();
    test_random(0, 2, 0, 0, 1);
    test_mid_reset();
    test_random(0, 3, 30, 30, 0);
    test_random(3, 2, 25, 25, 1);
    test_random(4, 2, 30, 20, 0);
    test_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
